// File: rtl/regfile.sv
// 32 x DATA_W register file: two combinational read ports, one sync write port.
// XZR (ZERO_REG) reads 0 and drops writes; optional bypass via REGFILE_BYPASS_EN.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low (entry i <= i)
//   we3          write enable (anything other than 1 means no write)
//   ra1/ra2      read addresses
//   wa3/wd3      write address / data
//   rd1/rd2      combinational read data
//
// Build option: define REGFILE_BYPASS_EN for same-cycle wd3 forwarding.
// Entries hold their index pattern once reset has been applied.
module regfile #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              rst_n
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  logic wr_en;
  logic byp1;
  logic byp2;

  // An X/Z we3 evaluates false in the if below, so it never writes.
  assign wr_en = (we3 == 1'b1) && (wa3 != ZR);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wa3] = wd3;
    end
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_en && rst_n && (wa3 == ra1);
  assign byp2 = wr_en && rst_n && (wa3 == ra2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // XZR check first; bypass can never hit it since wr_en excludes ZR.
  assign rd1 = (ra1 == ZR) ? '0 :
               byp1        ? wd3 : mem_q[ra1];
  assign rd2 = (ra2 == ZR) ? '0 :
               byp2        ? wd3 : mem_q[ra2];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
// Inputs change 1 time unit after posedge; checks follow after settle.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [63:0] rd1;
  logic [63:0] rd2;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk   (clk),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2),
    .rst_n (rst_n)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] wa,
                       input logic [63:0] wd);
    we3 = we; ra1 = a1; ra2 = a2; wa3 = wa; wd3 = wd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1: reset values, we3=0 does nothing
    drive(1'b0, 5'd0, 5'd1, 5'd0, 64'd35);
    chk("t1_rd1", rd1, 64'd0);
    chk("t1_rd2", rd2, 64'd1);
    step();
    chk("t1_x0_kept", rd1, 64'd0);

    // 2: write X2=27
    drive(1'b1, 5'd2, 5'd3, 5'd2, 64'd27);
`ifdef REGFILE_BYPASS_EN
    chk("t2_pre_byp", rd1, 64'd27);
`else
    chk("t2_pre", rd1, 64'd2);
`endif
    step();
    chk("t2_rd1", rd1, 64'd27);
    chk("t2_rd2", rd2, 64'd3);

    // 3: we3=0, no write
    drive(1'b0, 5'd4, 5'd5, 5'd4, 64'd28);
    step();
    chk("t3_rd1", rd1, 64'd4);
    chk("t3_rd2", rd2, 64'd5);

    // 4: sweep 6..29 in pairs
    for (int i = 6; i <= 28; i += 2) begin
      drive(1'b0, 5'(i), 5'(i + 1), 5'd0, 64'd0);
      chk($sformatf("t4_rd1_%0d", i), rd1, 64'(i));
      chk($sformatf("t4_rd2_%0d", i + 1), rd2, 64'(i + 1));
      step();
    end

    // 5: write to XZR discarded
    drive(1'b1, 5'd30, 5'd31, 5'd31, 64'd52);
    chk("t5_pre_rd1", rd1, 64'd30);
    chk("t5_pre_rd2", rd2, 64'd0);
    step();
    chk("t5_post_rd1", rd1, 64'd30);
    chk("t5_post_rd2", rd2, 64'd0);

    // X0 is writable
    drive(1'b1, 5'd0, 5'd31, 5'd0, 64'h1234);
    step();
    chk("x0_write", rd1, 64'h1234);

    // 6: X5=99, then reset beats a concurrent write to X6
    drive(1'b1, 5'd5, 5'd6, 5'd5, 64'd99);
    step();
    chk("t6_x5_99", rd1, 64'd99);
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd6, 5'd6, 64'd77);
    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd5, 5'd6, 5'd0, 64'd0);
    chk("t6_x5_rst", rd1, 64'd5);
    chk("t6_x6_rst", rd2, 64'd6);
    drive(1'b0, 5'd2, 5'd0, 5'd0, 64'd0);
    chk("t6_x2_rst", rd1, 64'd2);
    chk("t6_x0_rst", rd2, 64'd0);

    // bypass / no-bypass on X7
    drive(1'b1, 5'd7, 5'd7, 5'd7, 64'd123);
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd1", rd1, 64'd123);
    chk("byp_rd2", rd2, 64'd123);
`else
    chk("nobyp_rd1", rd1, 64'd7);
    chk("nobyp_rd2", rd2, 64'd7);
`endif
    step();
    we3 = 1'b0;
    #1;
    chk("x7_post", rd1, 64'd123);

    // write to 31 must not land in any other entry
    drive(1'b1, 5'd31, 5'd31, 5'd31, 64'hDEAD);
    step();
    drive(1'b0, 5'd31, 5'd29, 5'd0, 64'd0);
    chk("xzr_read", rd1, 64'd0);
    chk("x29_intact", rd2, 64'd29);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
